// File: rtl/transmitter.sv
// UART-style serial transmitter: loads a byte on request, then shifts out a start bit
// and DATA_W data bits LSB-first, one bit per external baud tick.
module transmitter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_rate_generator,
  input  logic              transmit_enable,
  input  logic [DATA_W-1:0] transmit_buffer,
  output logic              TBR,
  output logic              TxD
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StStart,
    StData,
    StDone
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                r_txd;
  logic                w_txd_nxt;
  logic                r_tbr;
  logic                w_tbr_nxt;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_cnt   <= '0;
      r_txd   <= 1'b1;
      r_tbr   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_txd   <= w_txd_nxt;
      r_tbr   <= w_tbr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_txd_nxt   = r_txd;
    w_tbr_nxt   = r_tbr;
    unique case (r_state)
      StIdle: begin
        w_txd_nxt = 1'b1;
        w_tbr_nxt = 1'b1;
        // A tick coinciding with the load is deliberately not used as the start bit.
        if (transmit_enable) begin
          w_shift_nxt = transmit_buffer;
          w_cnt_nxt   = '0;
          w_tbr_nxt   = 1'b0;
          w_state_nxt = StWaitStart;
        end
      end
      StWaitStart: begin
        if (baud_rate_generator) begin
          w_txd_nxt   = 1'b0;
          w_state_nxt = StStart;
        end
      end
      StStart: begin
        if (baud_rate_generator) begin
          w_txd_nxt   = r_shift[0];
          w_cnt_nxt   = '0;
          w_state_nxt = StData;
        end
      end
      StData: begin
        // Last bit is already on the line: report ready one clock later, no tick needed.
        if (r_cnt == LastBit) begin
          w_tbr_nxt   = 1'b1;
          w_state_nxt = StDone;
        end else if (baud_rate_generator) begin
          w_cnt_nxt = w_cnt_inc;
          w_txd_nxt = r_shift[w_cnt_inc];
        end
      end
      StDone: begin
        w_tbr_nxt = 1'b1;
        if (baud_rate_generator || !transmit_enable) begin
          w_txd_nxt   = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_txd_nxt   = 1'b1;
        w_tbr_nxt   = 1'b1;
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign TxD = r_txd;
  assign TBR = r_tbr;

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter: per-clock vector table plus hand-written frame,
// idle-tick and mid-frame reset sequences.
module tb_transmitter;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       en;
  logic [7:0] data;
  logic       tbr;
  logic       txd;

  int checks;
  int errors;

  transmitter #(.DATA_W(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .baud_rate_generator (tick),
    .transmit_enable     (en),
    .transmit_buffer     (data),
    .TBR                 (tbr),
    .TxD                 (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic       en;
    logic [7:0] data;
    logic       exp_txd;
    logic       exp_tbr;
  } vec_t;

  vec_t vecs[32];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, observe registered outputs just after the rising edge.
  task automatic step(input logic t, input logic e, input logic [7:0] d);
    @(negedge clk);
    tick = t;
    en   = e;
    data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int period, input string tag);
    logic [8:0] fr;
    fr = {b, 1'b0};
    step(1'b0, 1'b1, b);
    chk({tag, " load tbr"}, tbr, 1'b0);
    chk({tag, " load txd"}, txd, 1'b1);
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < period - 1; j++) step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      chk($sformatf("%s bit%0d txd", tag, k), txd, fr[k]);
      chk($sformatf("%s bit%0d tbr", tag, k), tbr, 1'b0);
    end
    step(1'b0, 1'b0, 8'h00);
    chk({tag, " done tbr"}, tbr, 1'b1);
    chk({tag, " done txd"}, txd, b[7]);
    step(1'b0, 1'b0, 8'h00);
    chk({tag, " stop txd"}, txd, 1'b1);
    chk({tag, " stop tbr"}, tbr, 1'b1);
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b0, 8'h00);
      chk({tag, " gap tbr"}, tbr, 1'b1);
      chk({tag, " gap txd"}, txd, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes[15];
    checks = 0;
    errors = 0;

    // A5 frame (LSB first 1,0,1,0,0,1,0,1), then 4B frame (1,1,0,1,0,0,1,0)
    vecs[0]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 8'h4B, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 8'h4B, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 8'h4B, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 8'h4B, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 8'h4B, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 8'h4B, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 8'h4B, 1'b1, 1'b0};
    vecs[23] = '{1'b1, 1'b1, 8'h4B, 1'b0, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 8'h4B, 1'b0, 1'b0};
    vecs[25] = '{1'b1, 1'b1, 8'h4B, 1'b1, 1'b0};
    vecs[26] = '{1'b1, 1'b1, 8'h4B, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 1'b1, 8'h4B, 1'b0, 1'b1};
    vecs[28] = '{1'b0, 1'b1, 8'h4B, 1'b0, 1'b1};
    vecs[29] = '{1'b1, 1'b1, 8'h4B, 1'b1, 1'b1};
    vecs[30] = '{1'b0, 1'b1, 8'h4B, 1'b1, 1'b0};
    vecs[31] = '{1'b0, 1'b0, 8'h4B, 1'b1, 1'b0};

    reset = 1'b0;
    tick  = 1'b0;
    en    = 1'b0;
    data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("in-reset txd", txd, 1'b1);
    chk("in-reset tbr", tbr, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);
    chk("post-reset txd", txd, 1'b1);
    chk("post-reset tbr", tbr, 1'b1);

    for (int i = 0; i < 32; i++) begin
      step(vecs[i].tick, vecs[i].en, vecs[i].data);
      chk($sformatf("vec%0d txd", i), txd, vecs[i].exp_txd);
      chk($sformatf("vec%0d tbr", i), tbr, vecs[i].exp_tbr);
    end

    // Async reset while waiting for the start tick
    #2 reset = 1'b0;
    #1;
    chk("rst-wait txd", txd, 1'b1);
    chk("rst-wait tbr", tbr, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    // Ticks while idle with enable low are ignored
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 8'hFF);
      chk("idle-tick txd", txd, 1'b1);
      chk("idle-tick tbr", tbr, 1'b1);
    end

    // Reset right after data bit 3 of C3 (bit3 = 0) aborts the frame
    step(1'b0, 1'b1, 8'hC3);
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'h00);
    chk("pre-abort txd", txd, 1'b0);
    chk("pre-abort tbr", tbr, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("abort txd", txd, 1'b1);
    chk("abort tbr", tbr, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 8'h00);
    chk("post-abort txd", txd, 1'b1);
    chk("post-abort tbr", tbr, 1'b1);
    send_frame(8'h96, 9, "fresh");

    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    for (int i = 2; i < 15; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 15; i++) begin
      send_frame(bytes[i], 3 + (i % 7), $sformatf("frm%0d_%02h", i, bytes[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
